// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready request -> SETUP/ACCESS -> registered response.
// Latency: 3 cycles from request to rsp_valid plus one per wait state. req_ready is low until the response is taken.
module apb_master_bridge #(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              apb_pclk,
  input  logic              apb_prstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic              apb_pwrite,
  output logic [31:0]       apb_pwdata,
  input  logic [31:0]       apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr
);

  localparam int CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CNT_MAX_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_I);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_psel, w_psel_nxt;
  logic                r_penable, w_penable_nxt;
  logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
  logic                r_pwrite, w_pwrite_nxt;
  logic [31:0]         r_pwdata, w_pwdata_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]         r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic                r_rsp_timeout, w_rsp_timeout_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

  always_comb begin
    w_state_nxt       = r_state;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_paddr_nxt       = r_paddr;
    w_pwrite_nxt      = r_pwrite;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_cnt_nxt         = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_paddr_nxt  = req_addr;
          w_pwrite_nxt = req_write;
          if (req_write) w_pwdata_nxt = req_wdata;
          w_psel_nxt   = 1'b1;
          w_state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        // pready wins over a timeout landing on the same cycle
        if (apb_pready) begin
          w_rsp_rdata_nxt   = r_pwrite ? 32'h0 : apb_prdata;
          w_rsp_err_nxt     = apb_pslverr;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_state_nxt       = S_RESP;
        end else if ((TIMEOUT_CYC != 0) && (r_cnt == CNT_MAX)) begin
          w_rsp_rdata_nxt   = 32'h0;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_valid_nxt   = 1'b1;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_state_nxt       = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      r_state       <= S_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= 32'h0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'h0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign apb_psel    = r_psel;
  assign apb_penable = r_penable;
  assign apb_paddr   = r_paddr;
  assign apb_pwrite  = r_pwrite;
  assign apb_pwdata  = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised bench for apb_master_bridge with a wait-state-programmable APB slave model.
module tb_apb_master_bridge;
  localparam int AW = 12;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic          apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
  logic [AW-1:0] apb_paddr;
  logic [31:0]   apb_pwdata, apb_prdata;

  int checks = 0;
  int errors = 0;

  int            slv_waits;
  logic [31:0]   slv_prdata;
  logic          slv_err;
  int            acc_cnt = 0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_wdata;

  apb_master_bridge #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .apb_pclk(clk), .apb_prstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_paddr(apb_paddr),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  always #5 clk = ~clk;

  // Slave: holds pready low for slv_waits ACCESS cycles, then raises it.
  always @(negedge clk) begin
    if (apb_psel && apb_penable) begin
      apb_pready = (acc_cnt == slv_waits);
      acc_cnt++;
    end else begin
      apb_pready = 1'b0;
      acc_cnt = 0;
    end
    apb_prdata  = slv_prdata;
    apb_pslverr = slv_err;
  end

  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic se, input int waits,
                         input int bp, input string name);
    int          n;
    int          e_lat;
    logic        e_err, e_to, bus_ok, stable_ok;
    logic [31:0] e_rdata, e_pwdata;
    // Reference: a transfer not answered within TO ACCESS cycles times out.
    if (TO != 0 && waits >= TO) begin
      e_to = 1'b1; e_err = 1'b1; e_rdata = 32'h0; e_lat = 3 + TO - 1;
    end else begin
      e_to = 1'b0; e_err = se; e_rdata = wr ? 32'h0 : rd; e_lat = 3 + waits;
    end
    e_pwdata = wr ? wd : last_wdata;
    slv_waits = waits; slv_prdata = rd; slv_err = se;

    @(negedge clk);
    checks++;
    if (apb_paddr !== last_addr || apb_pwdata !== last_wdata || req_ready !== 1'b1 || apb_psel !== 1'b0)
      begin errors++; $display("FAIL %s_idle got paddr=%h pwdata=%h rdy=%b psel=%b exp paddr=%h pwdata=%h rdy=1 psel=0",
                               name, apb_paddr, apb_pwdata, req_ready, apb_psel, last_addr, last_wdata); end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = $urandom; req_write = 1'($urandom);
    n = 1;
    checks++;
    if (apb_psel !== 1'b1 || apb_penable !== 1'b0 || apb_paddr !== addr || apb_pwrite !== wr || req_ready !== 1'b0)
      begin errors++; $display("FAIL %s_setup got psel=%b pen=%b paddr=%h pwrite=%b rdy=%b exp 1 0 %h %b 0",
                               name, apb_psel, apb_penable, apb_paddr, apb_pwrite, req_ready, addr, wr); end
    bus_ok = 1'b1;
    while (rsp_valid !== 1'b1 && n < 80) begin
      if (n >= 2 && (apb_psel !== 1'b1 || apb_penable !== 1'b1 || apb_paddr !== addr ||
                     apb_pwrite !== wr || apb_pwdata !== e_pwdata || req_ready !== 1'b0))
        bus_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== e_lat) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, n, e_lat); end
    checks++;
    if (!bus_ok) begin errors++; $display("FAIL %s_access_hold got unstable exp stable pwdata=%h", name, e_pwdata); end
    checks++;
    if (rsp_rdata !== e_rdata || rsp_err !== e_err || rsp_timeout !== e_to || apb_psel !== 1'b0 || apb_penable !== 1'b0)
      begin errors++; $display("FAIL %s_rsp got rdata=%h err=%b to=%b psel=%b pen=%b exp rdata=%h err=%b to=%b psel=0 pen=0",
                               name, rsp_rdata, rsp_err, rsp_timeout, apb_psel, apb_penable, e_rdata, e_err, e_to); end
    last_addr = addr;
    if (wr) last_wdata = wd;

    stable_ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = AW'($urandom); req_write = 1'($urandom);
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e_rdata || rsp_err !== e_err || rsp_timeout !== e_to ||
          req_ready !== 1'b0 || apb_psel !== 1'b0 || apb_paddr !== last_addr)
        stable_ok = 1'b0;
    end
    if (bp > 0) begin
      checks++;
      if (!stable_ok) begin errors++; $display("FAIL %s_backpressure got rsp/bus changed exp held for %0d cycles", name, bp); end
    end
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = AW'($urandom);
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || apb_psel !== 1'b0 || apb_paddr !== last_addr)
      begin errors++; $display("FAIL %s_handshake got vld=%b rdy=%b psel=%b paddr=%h exp 0 1 0 %h",
                               name, rsp_valid, req_ready, apb_psel, apb_paddr, last_addr); end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    slv_waits = 0; slv_prdata = 32'h0; slv_err = 1'b0;
    last_addr = '0; last_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (apb_psel !== 1'b0 || apb_penable !== 1'b0 || apb_paddr !== '0 || apb_pwrite !== 1'b0 ||
        apb_pwdata !== 32'h0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        rsp_timeout !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL reset got psel=%b pen=%b paddr=%h pw=%b pwd=%h vld=%b rd=%h err=%b to=%b rdy=%b exp all 0 rdy=1",
                               apb_psel, apb_penable, apb_paddr, apb_pwrite, apb_pwdata, rsp_valid, rsp_rdata,
                               rsp_err, rsp_timeout, req_ready); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_read();
    do_xfer(1'b0, 12'h004, 32'h0, 32'h1234_5678, 1'b0, 0, 0, "read");
  endtask

  task automatic test_write_wait();
    do_xfer(1'b1, 12'h008, 32'hDEAD_BEEF, 32'h5555_AAAA, 1'b0, 3, 0, "write_wait");
  endtask

  task automatic test_slverr();
    do_xfer(1'b0, 12'h010, 32'h0, 32'hCAFE_F00D, 1'b1, 0, 0, "slverr");
    do_xfer(1'b1, 12'h014, 32'h0BAD_0BAD, 32'h1111_2222, 1'b1, 2, 0, "slverr_wr");
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 12'h020, 32'h0, 32'h7777_7777, 1'b1, 1000, 0, "timeout");
    do_xfer(1'b0, 12'h024, 32'h0, 32'h8888_9999, 1'b0, TO - 1, 0, "timeout_edge");
    do_xfer(1'b1, 12'h028, 32'h1357_9BDF, 32'h0, 1'b0, TO, 0, "timeout_wr");
  endtask

  task automatic test_backpressure();
    do_xfer(1'b0, 12'h030, 32'h0, 32'hA5A5_5A5A, 1'b0, 1, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    w = 0;
        2:       w = $urandom_range(1, 4);
        3:       w = $urandom_range(TO - 2, TO - 1);
        4:       w = TO + $urandom_range(0, 4);
        default: w = $urandom_range(0, TO - 1);
      endcase
      do_xfer(1'($urandom), AW'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) == 0),
              w, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid();
    int hits;
    slv_waits = 1000; slv_prdata = 32'h4242_4242; slv_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h0FC; req_wdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (apb_psel !== 1'b1 || apb_penable !== 1'b1)
      begin errors++; $display("FAIL reset_mid_pre got psel=%b pen=%b exp 1 1", apb_psel, apb_penable); end
    rstn = 1'b0;
    #1;
    checks++;
    if (apb_psel !== 1'b0 || apb_penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL reset_mid_async got psel=%b pen=%b vld=%b rdy=%b exp 0 0 0 1",
                               apb_psel, apb_penable, rsp_valid, req_ready); end
    @(negedge clk);
    rstn = 1'b1;
    last_addr = '0; last_wdata = 32'h0;
    hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || apb_psel !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL reset_mid_no_rsp got %0d active cycles exp 0", hits); end
    do_xfer(1'b0, 12'h040, 32'h0, 32'h0F0F_F0F0, 1'b0, 0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
